// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and overflow-limit helper for the sequential BCD converter.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  typedef enum logic {IDLE, SHIFT} bcd_state_t;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more (4-bit wrap, no carry out).
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CW    = $clog2(WIDTH) + 1;
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  bcd_state_t state, state_next;

  logic [WIDTH-1:0]          sreg;
  logic [4*DIGITS-1:0]       scratch;
  logic [4*DIGITS-1:0]       adj;
  logic [4*DIGITS+WIDTH-1:0] shifted;
  logic [4*DIGITS-1:0]       result;
  logic [CW-1:0]             count;
  logic                      ovf_pending;
  logic                      accept;
  logic                      last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

  // Top digit MSB falls off the left end of the combined shift.
  assign shifted = {adj, sreg} << 1;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == '0) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result = shifted[4*DIGITS+WIDTH-1:WIDTH];
`ifdef BCD_LEADING_ZERO_BLANK_EN
    begin
      logic blanking;
      blanking = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        if (blanking && result[4*i +: 4] == 4'd0) result[4*i +: 4] = BCD_BLANK;
        else blanking = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg        <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      bcd         <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sreg        <= binary;
        scratch     <= '0;
        count       <= CW'(WIDTH - 1);
        ovf_pending <= (64'(binary) > LIMIT);
      end else if (state == SHIFT) begin
        sreg    <= shifted[WIDTH-1:0];
        scratch <= shifted[4*DIGITS+WIDTH-1:WIDTH];
        count   <= count - 1'b1;
        if (last) begin
          bcd  <= ovf_pending ? {DIGITS{BCD_NINE}} : result;
          ovf  <= ovf_pending;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: two instances (7b/2 digits and 16b/5 digits).
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start7, start16;
  logic [6:0]  bin7;
  logic [15:0] bin16;
  logic        busy7, done7, ovf7;
  logic        busy16, done16, ovf16;
  logic [7:0]  bcd7;
  logic [19:0] bcd16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(7), .DIGITS(2)) u7 (
    .clk(clk), .rst(rst), .start(start7), .binary(bin7),
    .busy(busy7), .done(done7), .ovf(ovf7), .bcd(bcd7)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u16 (
    .clk(clk), .rst(rst), .start(start16), .binary(bin16),
    .busy(busy16), .done(done16), .ovf(ovf16), .bcd(bcd16)
  );

  // Reference: decimal digits by division, saturate above 10^digits-1, optional blanking.
  function automatic logic [40:0] model(input int digits, input logic [31:0] v);
    logic [63:0] lim, t;
    logic [39:0] r;
    logic        o;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) lim = lim * 64'd10;
    lim = lim - 64'd1;
    r = '0;
    t = 64'(v);
    o = (t > lim);
    if (o) begin
      for (int k = 0; k < digits; k++) r[4*k +: 4] = 4'd9;
    end else begin
      for (int k = 0; k < digits; k++) begin
        r[4*k +: 4] = 4'(t % 64'd10);
        t = t / 64'd10;
      end
`ifdef BCD_LEADING_ZERO_BLANK_EN
      for (int k = digits - 1; k >= 1; k--) begin
        if (r[4*k +: 4] != 4'd0) break;
        r[4*k +: 4] = 4'hF;
      end
`endif
    end
    return {o, r};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_start(input int d, input logic s, input logic [31:0] v);
    if (d == 0) begin start7 = s; bin7 = v[6:0]; end
    else begin start16 = s; bin16 = v[15:0]; end
  endtask

  function automatic logic get_done(input int d);
    return (d == 0) ? done7 : done16;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy7 : busy16;
  endfunction

  function automatic logic get_ovf(input int d);
    return (d == 0) ? ovf7 : ovf16;
  endfunction

  function automatic logic [39:0] get_bcd(input int d);
    return (d == 0) ? 40'(bcd7) : 40'(bcd16);
  endfunction

  function automatic int width_of(input int d);
    return (d == 0) ? 7 : 16;
  endfunction

  function automatic int digits_of(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  task automatic convert(input int d, input logic [31:0] v, output logic [39:0] gb,
                         output logic go, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    set_start(d, 1'b1, v);
    @(posedge clk); #1;
    set_start(d, 1'b0, 32'd0);
    lat = 0;
    busy_cnt = 0;
    while (!get_done(d) && lat < 200) begin
      if (get_busy(d)) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    gb = get_bcd(d);
    go = get_ovf(d);
  endtask

  typedef struct {
    int          d;
    logic [31:0] val;
    logic [39:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [39:0] gb;
    logic        go;
    logic [40:0] m;
    int          lat, bc, c, n_done;
    logic [31:0] v;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    vecs[0]  = '{0, 32'd99,    40'h99,    1'b0};
    vecs[1]  = '{0, 32'd0,     40'hF0,    1'b0};
    vecs[2]  = '{0, 32'd127,   40'h99,    1'b1};
    vecs[3]  = '{0, 32'd100,   40'h99,    1'b1};
    vecs[4]  = '{0, 32'd5,     40'hF5,    1'b0};
    vecs[5]  = '{0, 32'd10,    40'h10,    1'b0};
    vecs[6]  = '{1, 32'd65535, 40'h65535, 1'b0};
    vecs[7]  = '{1, 32'd7,     40'hFFFF7, 1'b0};
    vecs[8]  = '{1, 32'd0,     40'hFFFF0, 1'b0};
    vecs[9]  = '{1, 32'd10000, 40'h10000, 1'b0};
    vecs[10] = '{1, 32'd909,   40'hFF909, 1'b0};
`else
    vecs[0]  = '{0, 32'd99,    40'h99,    1'b0};
    vecs[1]  = '{0, 32'd0,     40'h00,    1'b0};
    vecs[2]  = '{0, 32'd127,   40'h99,    1'b1};
    vecs[3]  = '{0, 32'd100,   40'h99,    1'b1};
    vecs[4]  = '{0, 32'd5,     40'h05,    1'b0};
    vecs[5]  = '{0, 32'd10,    40'h10,    1'b0};
    vecs[6]  = '{1, 32'd65535, 40'h65535, 1'b0};
    vecs[7]  = '{1, 32'd7,     40'h00007, 1'b0};
    vecs[8]  = '{1, 32'd0,     40'h00000, 1'b0};
    vecs[9]  = '{1, 32'd10000, 40'h10000, 1'b0};
    vecs[10] = '{1, 32'd909,   40'h00909, 1'b0};
`endif

    rst = 1'b1;
    start7 = 1'b0; start16 = 1'b0; bin7 = '0; bin16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy7", 64'(busy7), 64'd0);
    check("rst_done7", 64'(done7), 64'd0);
    check("rst_bcd7",  64'(bcd7),  64'd0);
    check("rst_ovf7",  64'(ovf7),  64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_bcd16",  64'(bcd16),  64'd0);

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].d, vecs[i].val, gb, go, lat, bc);
      check("tbl_bcd", 64'(gb), 64'(vecs[i].exp_bcd));
      check("tbl_ovf", 64'(go), 64'(vecs[i].exp_ovf));
      check("tbl_latency", 64'(lat), 64'(width_of(vecs[i].d)));
      check("tbl_busy_cycles", 64'(bc), 64'(width_of(vecs[i].d)));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(get_done(vecs[i].d)), 64'd0);
      check("bcd_held", 64'(get_bcd(vecs[i].d)), 64'(vecs[i].exp_bcd));
    end

    for (int i = 0; i < 60; i++) begin
      int d;
      d = (i < 30) ? 0 : 1;
      v = (d == 0) ? 32'($urandom_range(0, 127)) : 32'($urandom_range(0, 65535));
      m = model(digits_of(d), v);
      convert(d, v, gb, go, lat, bc);
      check("rnd_bcd", 64'(gb), 64'(m[39:0]));
      check("rnd_ovf", 64'(go), 64'(m[40]));
      check("rnd_latency", 64'(lat), 64'(width_of(d)));
    end

    // Back-to-back: start held high through done; binary changed while busy.
    @(posedge clk); #1;
    set_start(0, 1'b1, 32'd0);
    @(posedge clk); #1;
    set_start(0, 1'b1, 32'd127);
    c = 0;
    while (!done7 && c < 50) begin @(posedge clk); #1; c++; end
    m = model(2, 32'd0);
    check("b2b_first_bcd", 64'(bcd7), 64'(m[39:0]));
    check("b2b_first_ovf", 64'(ovf7), 64'd0);
    c = 0;
    @(posedge clk); #1; c++;
    set_start(0, 1'b0, 32'd0);
    while (!done7 && c < 50) begin @(posedge clk); #1; c++; end
    check("b2b_gap", 64'(c), 64'd8);
    check("b2b_second_bcd", 64'(bcd7), 64'h99);
    check("b2b_second_ovf", 64'(ovf7), 64'd1);

    // Start pulsed mid-conversion with a new value must be ignored.
    @(posedge clk); #1;
    set_start(1, 1'b1, 32'd1234);
    @(posedge clk); #1;
    set_start(1, 1'b0, 32'd4321);
    n_done = 0;
    gb = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) set_start(1, 1'b1, 32'd4321);
      if (k == 5) set_start(1, 1'b0, 32'd4321);
      if (done16) begin n_done++; gb = 40'(bcd16); end
      @(posedge clk); #1;
    end
    m = model(5, 32'd1234);
    check("midstart_done_count", 64'(n_done), 64'd1);
    check("midstart_bcd", 64'(gb), 64'(m[39:0]));

    // Asynchronous reset between edges during SHIFT.
    convert(1, 32'd65535, gb, go, lat, bc);
    check("pre_rst_bcd", 64'(gb), 64'h65535);
    @(posedge clk); #1;
    set_start(1, 1'b1, 32'd4321);
    @(posedge clk); #1;
    set_start(1, 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy16), 64'd0);
    check("arst_done", 64'(done16), 64'd0);
    check("arst_bcd",  64'(bcd16),  64'd0);
    check("arst_ovf",  64'(ovf16),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done16 || busy16) n_done++;
    end
    check("arst_no_done", 64'(n_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
